// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap/return sequencer.
//  - FSM state and sequence-kind encodings
//  - mcause codes (low bits; the interrupt flag is the MSB, added by the top)
//  - mtvec mode values
//  - select_trap(): fixed-priority selection of the winning exception/interrupt
package trap_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTER  = 2'd1,
    ST_RETURN = 2'd2,
    ST_REDIR  = 2'd3
  } state_e;

  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_MRET = 1'b1
  } kind_e;

  localparam logic [3:0] CAUSE_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK   = 4'd3;
  localparam logic [3:0] CAUSE_ECALL    = 4'd11;
  localparam logic [3:0] CAUSE_IRQ_EXT  = 4'd11;
  localparam logic [3:0] CAUSE_IRQ_SW   = 4'd3;
  localparam logic [3:0] CAUSE_IRQ_TMR  = 4'd7;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

  typedef struct packed {
    logic       hit;     // some exception or interrupt wins
    logic       is_irq;  // winner is an interrupt
    logic [3:0] code;    // mcause low bits
  } trap_sel_t;

  // Synchronous exceptions always beat interrupts; pend is {ext, sw, tmr}.
  function automatic trap_sel_t select_trap(input logic       misalign,
                                            input logic       illegal,
                                            input logic       ebreak,
                                            input logic       ecall,
                                            input logic [2:0] pend);
    trap_sel_t sel;
    sel = '{hit: 1'b1, is_irq: 1'b0, code: 4'd0};
    if (misalign) begin
      sel.code = CAUSE_MISALIGN;
    end else if (illegal) begin
      sel.code = CAUSE_ILLEGAL;
    end else if (ebreak) begin
      sel.code = CAUSE_EBREAK;
    end else if (ecall) begin
      sel.code = CAUSE_ECALL;
    end else if (pend[2]) begin
      sel.is_irq = 1'b1;
      sel.code   = CAUSE_IRQ_EXT;
    end else if (pend[1]) begin
      sel.is_irq = 1'b1;
      sel.code   = CAUSE_IRQ_SW;
    end else if (pend[0]) begin
      sel.is_irq = 1'b1;
      sel.code   = CAUSE_IRQ_TMR;
    end else begin
      sel.hit = 1'b0;
    end
    return sel;
  endfunction

endpackage

// File: rtl/trap_sequencer_irq_sync.sv
// Multi-flop synchronizer for one asynchronous interrupt level.
// Ports:
//  clk      in  clock
//  reset_x  in  asynchronous active-low reset, clears every stage
//  irq      in  asynchronous interrupt level
//  sync     out irq delayed by SYNC_STAGES clock edges
module trap_sequencer_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_x,
  input  logic irq,
  output logic sync
);

  logic [SYNC_STAGES-1:0] stage_r;

  // Shift the asynchronous level through the synchronizer chain.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      stage_r <= {SYNC_STAGES{1'b0}};
    end else begin
      stage_r <= {stage_r[SYNC_STAGES-2:0], irq};
    end
  end

  assign sync = stage_r[SYNC_STAGES-1];

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap/return sequencer.
// Picks the highest-priority exception or enabled interrupt on a valid
// instruction in IDLE (or an mret), then sequences:
//   trap: ENTER (Do_trap_take, Do_cause/Do_epc) -> REDIR (Do_redirect to mtvec target)
//   mret: RETURN (Do_mret_take)                 -> REDIR (Do_redirect to Di_mepc)
// Ports:
//  clk, reset_x          clock, asynchronous active-low reset
//  Di_valid, Di_PC       retiring instruction and its PC
//  Di_ecall/ebreak/illegal/misalign/mret  decoded events
//  Di_irq_ext/sw/tmr     asynchronous interrupt levels
//  Di_mstatus_mie, Di_mie {MEIE,MSIE,MTIE}, Di_mtvec, Di_mepc  CSR state
//  Do_trap_take, Do_mret_take  one-cycle CSR update pulses
//  Do_cause, Do_epc      values for mcause/mepc, held between pulses
//  Do_redirect, Do_redirect_pc  one-cycle PC redirect and target
//  Do_stall              hold the core while a sequence is detected or in flight
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset_x,
  input  logic            Di_valid,
  input  logic [XLEN-1:0] Di_PC,
  input  logic            Di_ecall,
  input  logic            Di_ebreak,
  input  logic            Di_illegal,
  input  logic            Di_misalign,
  input  logic            Di_mret,
  input  logic            Di_irq_ext,
  input  logic            Di_irq_sw,
  input  logic            Di_irq_tmr,
  input  logic            Di_mstatus_mie,
  input  logic [2:0]      Di_mie,
  input  logic [XLEN-1:0] Di_mtvec,
  input  logic [XLEN-1:0] Di_mepc,
  output logic            Do_trap_take,
  output logic            Do_mret_take,
  output logic [XLEN-1:0] Do_cause,
  output logic [XLEN-1:0] Do_epc,
  output logic            Do_redirect,
  output logic [XLEN-1:0] Do_redirect_pc,
  output logic            Do_stall
);

  state_e          state_r;
  kind_e           kind_r;
  logic [XLEN-1:0] cause_r;
  logic [XLEN-1:0] epc_r;
  logic [XLEN-1:0] trap_pc_r;
  logic            trap_take_r;
  logic            mret_take_r;
  logic            redirect_r;

  logic [2:0]      irq_sync_s;
  logic [2:0]      pend_s;
  trap_sel_t       sel_s;
  logic            idle_valid_s;
  logic            detect_trap_s;
  logic            detect_mret_s;
  logic [XLEN-1:0] cause_s;
  logic [XLEN-1:0] trap_target_s;

  trap_sequencer_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ext (
    .clk(clk), .reset_x(reset_x), .irq(Di_irq_ext), .sync(irq_sync_s[2])
  );
  trap_sequencer_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sw (
    .clk(clk), .reset_x(reset_x), .irq(Di_irq_sw), .sync(irq_sync_s[1])
  );
  trap_sequencer_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tmr (
    .clk(clk), .reset_x(reset_x), .irq(Di_irq_tmr), .sync(irq_sync_s[0])
  );

  // Detection of the winning event for the instruction presented in IDLE.
  always_comb begin
    pend_s        = irq_sync_s & Di_mie & {3{Di_mstatus_mie}};
    sel_s         = select_trap(Di_misalign, Di_illegal, Di_ebreak, Di_ecall, pend_s);
    idle_valid_s  = (state_r == ST_IDLE) && Di_valid;
    detect_trap_s = idle_valid_s && sel_s.hit;
    // Any exception or pending interrupt overrides a simultaneous mret.
    detect_mret_s = idle_valid_s && Di_mret && !sel_s.hit;
    cause_s       = {sel_s.is_irq, (XLEN-1)'(sel_s.code)};
  end

  // Trap vector: vectored mode offsets only interrupts; modes 2/3 act as direct.
  always_comb begin
    if ((Di_mtvec[1:0] == MTVEC_MODE_VECTORED) && cause_r[XLEN-1]) begin
      trap_target_s = {Di_mtvec[XLEN-1:2], 2'b00} + {cause_r[XLEN-3:0], 2'b00};
    end else begin
      trap_target_s = {Di_mtvec[XLEN-1:2], 2'b00};
    end
  end

  // Sequencer FSM with registered pulse outputs.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_r     <= ST_IDLE;
      kind_r      <= KIND_TRAP;
      cause_r     <= {XLEN{1'b0}};
      epc_r       <= {XLEN{1'b0}};
      trap_pc_r   <= {XLEN{1'b0}};
      trap_take_r <= 1'b0;
      mret_take_r <= 1'b0;
      redirect_r  <= 1'b0;
    end else begin
      trap_take_r <= 1'b0;
      mret_take_r <= 1'b0;
      redirect_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (detect_trap_s) begin
            state_r     <= ST_ENTER;
            kind_r      <= KIND_TRAP;
            cause_r     <= cause_s;
            epc_r       <= Di_PC;
            trap_take_r <= 1'b1;
          end else if (detect_mret_s) begin
            state_r     <= ST_RETURN;
            kind_r      <= KIND_MRET;
            mret_take_r <= 1'b1;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_ENTER: begin
          state_r    <= ST_REDIR;
          trap_pc_r  <= trap_target_s;
          redirect_r <= 1'b1;
        end
        ST_RETURN: begin
          state_r    <= ST_REDIR;
          redirect_r <= 1'b1;
        end
        ST_REDIR: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // mret target follows Di_mepc live in REDIR, i.e. after the CSR restore.
  always_comb begin
    if ((state_r == ST_REDIR) && (kind_r == KIND_MRET)) begin
      Do_redirect_pc = Di_mepc;
    end else begin
      Do_redirect_pc = trap_pc_r;
    end
  end

  assign Do_trap_take = trap_take_r;
  assign Do_mret_take = mret_take_r;
  assign Do_cause     = cause_r;
  assign Do_epc       = epc_r;
  assign Do_redirect  = redirect_r;
  assign Do_stall     = detect_trap_s || detect_mret_s || (state_r != ST_IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
module tb_trap_sequencer;

  localparam int XLEN = 32;
  localparam int SYNC = 2;

  logic            clk = 1'b0;
  logic            reset_x;
  logic            Di_valid, Di_ecall, Di_ebreak, Di_illegal, Di_misalign, Di_mret;
  logic            Di_irq_ext, Di_irq_sw, Di_irq_tmr, Di_mstatus_mie;
  logic [2:0]      Di_mie;
  logic [XLEN-1:0] Di_PC, Di_mtvec, Di_mepc;
  logic            Do_trap_take, Do_mret_take, Do_redirect, Do_stall;
  logic [XLEN-1:0] Do_cause, Do_epc, Do_redirect_pc;

  int checks   = 0;
  int failures = 0;

  trap_sequencer #(.XLEN(XLEN), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset_x(reset_x),
    .Di_valid(Di_valid), .Di_PC(Di_PC),
    .Di_ecall(Di_ecall), .Di_ebreak(Di_ebreak), .Di_illegal(Di_illegal),
    .Di_misalign(Di_misalign), .Di_mret(Di_mret),
    .Di_irq_ext(Di_irq_ext), .Di_irq_sw(Di_irq_sw), .Di_irq_tmr(Di_irq_tmr),
    .Di_mstatus_mie(Di_mstatus_mie), .Di_mie(Di_mie),
    .Di_mtvec(Di_mtvec), .Di_mepc(Di_mepc),
    .Do_trap_take(Do_trap_take), .Do_mret_take(Do_mret_take),
    .Do_cause(Do_cause), .Do_epc(Do_epc),
    .Do_redirect(Do_redirect), .Do_redirect_pc(Do_redirect_pc),
    .Do_stall(Do_stall)
  );

  always #5 clk = ~clk;

  task automatic clear_decode();
    Di_valid = 1'b0; Di_ecall = 1'b0; Di_ebreak = 1'b0;
    Di_illegal = 1'b0; Di_misalign = 1'b0; Di_mret = 1'b0;
  endtask

  task automatic clear_all();
    clear_decode();
    Di_irq_ext = 1'b0; Di_irq_sw = 1'b0; Di_irq_tmr = 1'b0;
    Di_mstatus_mie = 1'b0; Di_mie = 3'b000;
    Di_PC = 32'h0; Di_mtvec = 32'h0; Di_mepc = 32'h0;
  endtask

  // Advance to the next negedge and settle.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Called #1 after driving the detecting cycle N; follows N..N+3.
  task automatic observe_sequence(input string name, input bit is_mret,
                                  input logic [31:0] exp_cause, input logic [31:0] exp_epc,
                                  input logic [31:0] exp_pc);
    logic [3:0] exp_flags;
    // flags = {stall, trap_take, mret_take, redirect}
    if ({Do_stall, Do_trap_take, Do_mret_take, Do_redirect} !== 4'b1000) begin
      failures++; $display("FAIL %s N flags got=%b want=1000", name,
                           {Do_stall, Do_trap_take, Do_mret_take, Do_redirect});
    end
    checks++;
    @(negedge clk); clear_decode(); #1;
    exp_flags = is_mret ? 4'b1010 : 4'b1100;
    if ({Do_stall, Do_trap_take, Do_mret_take, Do_redirect} !== exp_flags) begin
      failures++; $display("FAIL %s N+1 flags got=%b want=%b", name,
                           {Do_stall, Do_trap_take, Do_mret_take, Do_redirect}, exp_flags);
    end
    checks++;
    if (!is_mret) begin
      if (Do_cause !== exp_cause || Do_epc !== exp_epc) begin
        failures++; $display("FAIL %s cause/epc got=%h/%h want=%h/%h", name,
                             Do_cause, Do_epc, exp_cause, exp_epc);
      end
      checks++;
    end
    step();
    if ({Do_stall, Do_trap_take, Do_mret_take, Do_redirect} !== 4'b1001 ||
        Do_redirect_pc !== exp_pc) begin
      failures++; $display("FAIL %s N+2 flags=%b pc=%h want flags=1001 pc=%h", name,
                           {Do_stall, Do_trap_take, Do_mret_take, Do_redirect},
                           Do_redirect_pc, exp_pc);
    end
    checks++;
    step();
    if ({Do_stall, Do_trap_take, Do_mret_take, Do_redirect} !== 4'b0000) begin
      failures++; $display("FAIL %s N+3 flags got=%b want=0000", name,
                           {Do_stall, Do_trap_take, Do_mret_take, Do_redirect});
    end
    checks++;
  endtask

  task automatic test_reset();
    clear_all();
    reset_x = 1'b0;
    #12;
    if ({Do_trap_take, Do_mret_take, Do_redirect, Do_stall} !== 4'b0000 ||
        Do_cause !== 32'h0 || Do_epc !== 32'h0 || Do_redirect_pc !== 32'h0) begin
      failures++; $display("FAIL reset outputs not zero take=%b cause=%h epc=%h pc=%h",
                           {Do_trap_take, Do_mret_take, Do_redirect, Do_stall},
                           Do_cause, Do_epc, Do_redirect_pc);
    end
    checks++;
    @(negedge clk); reset_x = 1'b1;
    step();
  endtask

  task automatic test_ecall();
    @(negedge clk);
    Di_valid = 1'b1; Di_ecall = 1'b1; Di_PC = 32'h100; Di_mtvec = 32'h200; #1;
    observe_sequence("ecall", 1'b0, 32'hB, 32'h100, 32'h200);
  endtask

  task automatic test_illegal_ecall();
    @(negedge clk);
    Di_valid = 1'b1; Di_ecall = 1'b1; Di_illegal = 1'b1; Di_PC = 32'h40; Di_mtvec = 32'h200; #1;
    observe_sequence("illegal_ecall", 1'b0, 32'h2, 32'h40, 32'h200);
    // Inputs went idle: no second sequence.
    step();
    if (Do_trap_take !== 1'b0 || Do_stall !== 1'b0) begin
      failures++; $display("FAIL illegal_ecall second sequence take=%b stall=%b",
                           Do_trap_take, Do_stall);
    end
    checks++;
  endtask

  task automatic test_timer_irq();
    int first_stall = -1;
    int first_take  = -1;
    @(negedge clk);
    Di_valid = 1'b1; Di_PC = 32'h500; Di_mtvec = 32'h301;
    Di_mstatus_mie = 1'b1; Di_mie = 3'b001; Di_irq_tmr = 1'b1;
    #1;
    for (int c = 0; c < 12 && first_take < 0; c++) begin
      if (Do_stall && first_stall < 0) first_stall = c;
      if (Do_trap_take) first_take = c;
      if (first_take < 0) step();
    end
    if (first_stall != SYNC || first_take != SYNC + 1) begin
      failures++; $display("FAIL timer_latency stall_at=%0d take_at=%0d want %0d/%0d",
                           first_stall, first_take, SYNC, SYNC + 1);
    end
    checks++;
    clear_decode(); Di_irq_tmr = 1'b0;
    if (Do_cause !== 32'h80000007 || Do_epc !== 32'h500) begin
      failures++; $display("FAIL timer_cause got=%h/%h want=80000007/00000500", Do_cause, Do_epc);
    end
    checks++;
    step();
    if (Do_redirect !== 1'b1 || Do_redirect_pc !== 32'h31C) begin
      failures++; $display("FAIL timer_redirect got=%b/%h want=1/0000031c", Do_redirect, Do_redirect_pc);
    end
    checks++;
    repeat (SYNC + 2) step();
    clear_all();
  endtask

  task automatic test_irq_masked();
    bit bad = 1'b0;
    @(negedge clk);
    Di_valid = 1'b1; Di_PC = 32'h600; Di_mtvec = 32'h1000;
    Di_mstatus_mie = 1'b0; Di_mie = 3'b100; Di_irq_ext = 1'b1;
    #1;
    for (int c = 0; c < SYNC + 4; c++) begin
      if (Do_stall !== 1'b0 || Do_trap_take !== 1'b0) bad = 1'b1;
      step();
    end
    if (bad) begin
      failures++; $display("FAIL irq_masked activity got=1 want=0");
    end
    checks++;
    @(negedge clk); Di_mstatus_mie = 1'b1; #1;
    observe_sequence("irq_ext", 1'b0, 32'h8000000B, 32'h600, 32'h1000);
    Di_irq_ext = 1'b0;
    repeat (SYNC + 2) step();
    clear_all();
  endtask

  task automatic test_mret();
    @(negedge clk);
    Di_valid = 1'b1; Di_mret = 1'b1; Di_mepc = 32'h104; Di_PC = 32'h700; #1;
    observe_sequence("mret", 1'b0 ^ 1'b1, 32'h0, 32'h0, 32'h104);
  endtask

  task automatic test_reset_mid();
    bit bad = 1'b0;
    @(negedge clk);
    Di_valid = 1'b1; Di_ebreak = 1'b1; Di_PC = 32'h800; Di_mtvec = 32'h900; #1;
    @(negedge clk); clear_decode(); #1;
    if (Do_trap_take !== 1'b1) begin
      failures++; $display("FAIL reset_mid enter got=%b want=1", Do_trap_take);
    end
    checks++;
    reset_x = 1'b0; #1;
    if ({Do_trap_take, Do_mret_take, Do_redirect, Do_stall} !== 4'b0000 ||
        Do_cause !== 32'h0 || Do_epc !== 32'h0) begin
      failures++; $display("FAIL reset_mid outputs got=%b cause=%h want=0000/0",
                           {Do_trap_take, Do_mret_take, Do_redirect, Do_stall}, Do_cause);
    end
    checks++;
    @(negedge clk); reset_x = 1'b1; #1;
    for (int c = 0; c < 5; c++) begin
      if (Do_redirect !== 1'b0 || Do_stall !== 1'b0 || Do_trap_take !== 1'b0) bad = 1'b1;
      step();
    end
    if (bad) begin
      failures++; $display("FAIL reset_mid post-release activity got=1 want=0");
    end
    checks++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      bit mis, ill, ebr, ecl, mrt, ie, is, it_, mmie;
      bit [2:0] mie, pend;
      bit hit, irq;
      logic [31:0] cause, base, target;
      mis = ($urandom_range(0, 5) == 0); ill = ($urandom_range(0, 5) == 0);
      ebr = ($urandom_range(0, 5) == 0); ecl = ($urandom_range(0, 5) == 0);
      mrt = ($urandom_range(0, 3) == 0);
      ie = $urandom_range(0, 1); is = $urandom_range(0, 1); it_ = $urandom_range(0, 1);
      mmie = $urandom_range(0, 1); mie = 3'($urandom_range(0, 7));
      // Let the interrupt levels propagate with no valid instruction.
      @(negedge clk);
      clear_decode();
      Di_irq_ext = ie; Di_irq_sw = is; Di_irq_tmr = it_;
      Di_mstatus_mie = mmie; Di_mie = mie;
      Di_mtvec = $urandom; Di_mepc = $urandom & 32'hFFFF_FFFC; Di_PC = $urandom & 32'hFFFF_FFFC;
      repeat (SYNC + 1) @(negedge clk);
      Di_valid = 1'b1; Di_misalign = mis; Di_illegal = ill; Di_ebreak = ebr;
      Di_ecall = ecl; Di_mret = mrt;
      #1;
      pend = {ie, is, it_} & mie & {3{mmie}};
      hit = 1'b1; irq = 1'b0;
      if (mis)          cause = 32'd0;
      else if (ill)     cause = 32'd2;
      else if (ebr)     cause = 32'd3;
      else if (ecl)     cause = 32'd11;
      else if (pend[2]) begin cause = 32'h8000000B; irq = 1'b1; end
      else if (pend[1]) begin cause = 32'h80000003; irq = 1'b1; end
      else if (pend[0]) begin cause = 32'h80000007; irq = 1'b1; end
      else begin cause = 32'h0; hit = 1'b0; end
      base = Di_mtvec & 32'hFFFF_FFFC;
      target = (irq && Di_mtvec[1:0] == 2'd1) ? base + cause * 32'd4 : base;
      if (hit) begin
        observe_sequence($sformatf("rand%0d", it), 1'b0, cause, Di_PC, target);
      end else if (mrt) begin
        observe_sequence($sformatf("rand%0d_mret", it), 1'b1, 32'h0, 32'h0, Di_mepc);
      end else begin
        if (Do_stall !== 1'b0) begin
          failures++; $display("FAIL rand%0d idle stall got=%b want=0", it, Do_stall);
        end
        checks++;
        step();
        if ({Do_trap_take, Do_mret_take} !== 2'b00) begin
          failures++; $display("FAIL rand%0d idle take got=%b want=00", it,
                               {Do_trap_take, Do_mret_take});
        end
        checks++;
      end
      clear_decode();
      Di_irq_ext = 1'b0; Di_irq_sw = 1'b0; Di_irq_tmr = 1'b0;
      repeat (SYNC + 1) @(negedge clk);
    end
    clear_all();
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_illegal_ecall();
    test_timer_irq();
    test_irq_masked();
    test_mret();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule
